// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplication-table writer.
package mult_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MULT, WRITE, DONE} wr_state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int table_depth(input int w);
    return 2 ** (2 * w);
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-add multiplication step: conditionally adds a << bit_idx to the accumulator.
module shift_add_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [IDX_W-1:0]   bit_idx,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] partial;

  always_comb begin
    partial  = {{WIDTH{1'b0}}, a} << bit_idx;
    acc_next = b_bit ? (acc + partial) : acc;
  end

endmodule

// File: rtl/mult_table_writer.sv
// Fills a RAM with the product table {a,b} -> a*b, one shift-add product per entry.
module mult_table_writer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [2*WIDTH-1:0] wr_addr,
  output logic [2*WIDTH-1:0] wr_data
);

  localparam int AW    = 2 * WIDTH;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  wr_state_t          state;
  logic [AW-1:0]      cnt;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_next;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [IDX_W-1:0]   bit_idx;

  assign busy = (state != IDLE);

  shift_add_step #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_step (
    .acc      (acc),
    .a        (op_a),
    .b_bit    (op_b[bit_idx]),
    .bit_idx  (bit_idx),
    .acc_next (acc_next)
  );

  // wr_en/done are registered on the edge that leaves WRITE/DONE, so they
  // appear one cycle after the state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      bit_idx <= '0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          op_a    <= cnt[AW-1:WIDTH];
          op_b    <= cnt[WIDTH-1:0];
          acc     <= '0;
          bit_idx <= '0;
          state   <= MULT;
        end
        MULT: begin
          acc     <= acc_next;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == IDX_W'(WIDTH - 1)) state <= WRITE;
        end
        WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= acc;
          // the all-ones entry ends the fill; the counter never wraps
          if (cnt == '1) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_table_writer.sv
// Randomized bench for mult_table_writer against a schedule/product model of the fill.
module tb_mult_table_writer;
  import mult_pkg::*;

  localparam int W     = 4;
  localparam int DW    = 2 * W;
  localparam int DEPTH = table_depth(W);
  localparam int ENTRY = W + 2;
  localparam int FILL  = DEPTH * ENTRY + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, wr_en;
  logic [DW-1:0] wr_addr, wr_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_table_writer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Model: a fill is a fixed schedule measured in edges from the start-sampling edge.
  bit            m_active = 1'b0;
  int            m_t      = 0;
  logic          e_busy   = 1'b0;
  logic          e_done   = 1'b0;
  logic          e_wr     = 1'b0;
  logic [DW-1:0] e_addr   = '0;
  logic [DW-1:0] e_data   = '0;

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      m_active = 1'b0; m_t = 0;
      e_busy = 1'b0; e_done = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
    end else begin
      e_wr = 1'b0;
      e_done = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t >= ENTRY && m_t % ENTRY == 0 && m_t <= DEPTH * ENTRY) begin
          k = m_t / ENTRY - 1;
          e_wr   = 1'b1;
          e_addr = DW'(k);
          e_data = DW'((k >> W) * (k % (1 << W)));
        end
        if (m_t == FILL) begin
          e_done   = 1'b1;
          m_active = 1'b0;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_t = 0;
      end
      e_busy = m_active;
    end
  end

  bit            seen [DEPTH];
  logic [DW-1:0] spot_a [5];
  logic [DW-1:0] spot_d [5];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
  endtask

  // Compare on the falling edge, then move 1 time unit on before driving inputs.
  task automatic tick();
    int nseen;
    int av, bv;
    @(negedge clk);
    chk("busy",    DW'(busy),  DW'(e_busy));
    chk("done",    DW'(done),  DW'(e_done));
    chk("wr_en",   DW'(wr_en), DW'(e_wr));
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    if (rst_n === 1'b0) clear_seen();
    if (wr_en === 1'b1) begin
      if (seen[wr_addr]) chk_int("repeated_addr", int'(wr_addr), -1);
      seen[wr_addr] = 1'b1;
      av = int'(wr_addr) >> W;
      bv = int'(wr_addr) % (1 << W);
      chk("product", wr_data, DW'(av * bv));
      for (int i = 0; i < 5; i++)
        if (wr_addr == spot_a[i]) chk("spot_value", wr_data, spot_d[i]);
    end
    if (done === 1'b1) begin
      nseen = 0;
      for (int i = 0; i < DEPTH; i++) nseen += int'(seen[i]);
      chk_int("addr_coverage", nseen, DEPTH);
      clear_seen();
    end
    #1;
  endtask

  // k counts edges after the start-sampling edge (the first posedge after start is driven).
  task automatic run_fill(input bit hold, input bit pulses, input int abort_addr,
                          output int first_lat, output int done_lat, output int nwr);
    int rnd_addr;
    rnd_addr  = $urandom_range(1, DEPTH - 2);
    first_lat = -1;
    done_lat  = -1;
    nwr       = 0;
    start     = 1'b1;
    for (int k = 0; k <= FILL + 10; k++) begin
      tick();
      if (!hold)
        start = pulses && (wr_en === 1'b1) &&
                (wr_addr == 8'h40 || wr_addr == 8'hFF || int'(wr_addr) == rnd_addr);
      if (wr_en === 1'b1) begin
        nwr++;
        if (first_lat < 0) first_lat = k;
      end
      if (abort_addr >= 0 && wr_en === 1'b1 && int'(wr_addr) == abort_addr) begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) begin
          tick();
          chk("rst_busy",    DW'(busy),  '0);
          chk("rst_done",    DW'(done),  '0);
          chk("rst_wr_en",   DW'(wr_en), '0);
          chk("rst_wr_addr", wr_addr,    '0);
          chk("rst_wr_data", wr_data,    '0);
        end
        rst_n = 1'b1;
        return;
      end
      if (done === 1'b1) begin
        done_lat = k;
        return;
      end
    end
    chk_int("fill_timeout", done_lat, FILL);
  endtask

  int f_lat, d_lat, nw;

  initial begin
    spot_a[0] = 8'h23; spot_d[0] = 8'h06;
    spot_a[1] = 8'h0F; spot_d[1] = 8'h00;
    spot_a[2] = 8'hF1; spot_d[2] = 8'h0F;
    spot_a[3] = 8'hFF; spot_d[3] = 8'hE1;
    spot_a[4] = 8'h00; spot_d[4] = 8'h00;
    clear_seen();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_busy",    DW'(busy),  '0);
    chk("idle_done",    DW'(done),  '0);
    chk("idle_wr_en",   DW'(wr_en), '0);
    chk("idle_wr_addr", wr_addr,    '0);
    chk("idle_wr_data", wr_data,    '0);

    run_fill(1'b0, 1'b0, -1, f_lat, d_lat, nw);
    chk_int("first_write_latency", f_lat, 6);
    chk_int("done_latency", d_lat, 1537);
    chk_int("write_count", nw, 256);
    repeat ($urandom_range(2, 12)) tick();

    run_fill(1'b0, 1'b1, -1, f_lat, d_lat, nw);
    chk_int("pulsed_write_count", nw, 256);
    chk_int("pulsed_done_latency", d_lat, 1537);
    repeat (20) tick();
    chk("no_restart_busy", DW'(busy), '0);

    run_fill(1'b0, 1'b0, 8'h80, f_lat, d_lat, nw);
    chk_int("aborted_write_count", nw, 8'h81);
    repeat ($urandom_range(2, 12)) tick();
    run_fill(1'b0, 1'b0, -1, f_lat, d_lat, nw);
    chk_int("refill_first_latency", f_lat, 6);
    chk_int("refill_write_count", nw, 256);
    chk_int("refill_done_latency", d_lat, 1537);
    repeat ($urandom_range(2, 12)) tick();

    run_fill(1'b1, 1'b0, -1, f_lat, d_lat, nw);
    chk_int("hold1_write_count", nw, 256);
    chk_int("hold1_done_latency", d_lat, 1537);
    run_fill(1'b1, 1'b0, -1, f_lat, d_lat, nw);
    start = 1'b0;
    chk_int("hold2_first_latency", f_lat, 6);
    chk_int("hold2_write_count", nw, 256);
    chk_int("hold2_done_latency", d_lat, 1537);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
